if_unit: RTL and testbench

Instruction fetch unit; the producer end of the decoder's i_reg input. It holds the fetch PC, issues one-outstanding word reads to instruction memory, and buffers returned words in a small FIFO. It presents them to decode with a valid/ready handshake. It also handles redirects from jump execution and a terminal halt when STOP executes.

---
 rtl/qisp_pkg.sv | 15 +
 rtl/if_fifo.sv | 52 +++++
 rtl/if_unit.sv | 150 +++++++++++++++
 tb/tb_if_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/qisp_pkg.sv
// Shared fetch-side types and constants: default widths, reset PC, fetch FSM states.
package qisp_pkg;

    localparam int          QISP_ADDR_W   = 16;
    localparam logic [15:0] QISP_RESET_PC = 16'h0000;
    localparam int          INSTR_W       = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/if_fifo.sv
// Instruction FIFO: registered head, same-cycle push/pop, synchronous flush.
// Latency: a push is visible at the head the next cycle; pop is ignored when empty.
module if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     head_vld
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign do_pop   = pop & head_vld;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: head is only observed while head_vld is set.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/if_unit.sv
// Instruction fetch: one outstanding memory read, buffered words to decode via valid/ready.
// Word is valid to decode the cycle after mem_ack; fetching pauses when the buffer has no room.
module if_unit
    import qisp_pkg::*;
#(
    parameter int                ADDR_W    = QISP_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(QISP_RESET_PC),
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] i_reg,
    output logic [ADDR_W-1:0]  i_pc,
    output logic               i_valid,
    input  logic               i_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, addr_nxt, last_pc;
    logic              req_nxt, halt_pend, halt_pend_nxt;
    logic              push, pop, flush, ack, head_vld, room;
    logic [CW-1:0]     count;
    logic [CW:0]       fill;
    entry_t            push_ent, head_ent;

    assign ack      = mem_req & mem_ack;
    assign push_ent = '{pc: pc, instr: mem_rdata};
    assign room     = count < CW'(BUF_DEPTH);
    assign fill     = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

    if_fifo #(.WIDTH($bits(entry_t)), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (flush),
        .count    (count),
        .head_dat (head_ent),
        .head_vld (head_vld)
    );

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        req_nxt       = mem_req;
        addr_nxt      = mem_addr;
        halt_pend_nxt = halt_pend;
        push          = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        if (state != HALTED) begin
            if (halt_pend) begin
                // Halt is waiting out the last handshake; everything else is ignored.
                if (ack) begin
                    state_nxt     = HALTED;
                    req_nxt       = 1'b0;
                    halt_pend_nxt = 1'b0;
                end
            end else if (halt) begin
                flush = 1'b1;
                if (mem_req && !ack) begin
                    state_nxt     = DROP;
                    halt_pend_nxt = 1'b1;
                end else begin
                    state_nxt = HALTED;
                    req_nxt   = 1'b0;
                end
            end else if (redirect) begin
                flush  = 1'b1;
                pc_nxt = redirect_pc;
                if (mem_req && !ack) begin
                    state_nxt = DROP;
                end else if (mem_req) begin
                    // Acked word belongs to the old stream; refetch from the target at once.
                    state_nxt = WAIT;
                    addr_nxt  = redirect_pc;
                end
            end else begin
                pop = head_vld & i_ready;
                case (state)
                    IDLE: if (room) begin
                        state_nxt = WAIT;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc;
                    end
                    WAIT: if (ack) begin
                        push   = 1'b1;
                        pc_nxt = pc + ADDR_W'(1);
                        if (fill < (CW+1)'(BUF_DEPTH)) begin
                            addr_nxt = pc_nxt;
                        end else begin
                            state_nxt = IDLE;
                            req_nxt   = 1'b0;
                        end
                    end
                    DROP: if (ack) begin
                        if (room) begin
                            state_nxt = WAIT;
                            addr_nxt  = pc;
                        end else begin
                            state_nxt = IDLE;
                            req_nxt   = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_addr  <= RESET_PC;
            halt_pend <= 1'b0;
            last_pc   <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            mem_req   <= req_nxt;
            mem_addr  <= addr_nxt;
            halt_pend <= halt_pend_nxt;
            if (head_vld)
                last_pc <= head_ent.pc;
        end
    end

    assign i_valid = head_vld;
    assign i_reg   = head_vld ? head_ent.instr : '0;
    assign i_pc    = head_vld ? head_ent.pc : last_pc;
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_if_unit.sv
// Directed bench for if_unit: a latency-configurable memory model and hand-computed expectations.
module tb_if_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_ack, i_valid, i_ready, redirect, halt, halted;
    logic [15:0] mem_addr, mem_rdata, i_reg, i_pc, redirect_pc;

    int   lat = 0;
    logic ack_en = 1'b1;
    int   wait_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] acc_q[$];
    logic [31:0] pop_q[$];
    logic [15:0] saved_addr;
    bit          found;

    if_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .i_reg       (i_reg),
        .i_pc        (i_pc),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Memory word for address a is a ^ 16'h5A00.
    assign mem_ack   = mem_req && ack_en && (wait_cnt >= lat);
    assign mem_rdata = mem_addr ^ 16'h5A00;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_ack)
                acc_q.push_back(mem_addr);
            if (i_valid && i_ready && !redirect && !halt)
                pop_q.push_back({i_pc, i_reg});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_q.size()) return {16'h0, acc_q[i]};
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        if (i < pop_q.size()) return pop_q[i];
        return 32'hDEADBEEF;
    endfunction

    task automatic do_reset(input int l, input logic rdy);
        rst         = 1'b1;
        lat         = l;
        ack_en      = 1'b1;
        i_ready     = rdy;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        acc_q.delete();
        pop_q.delete();
    endtask

    initial begin
        i_ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;

        // Reset values
        #12;
        chk("rst_req",    {31'h0, mem_req}, 32'h0);
        chk("rst_addr",   {16'h0, mem_addr}, 32'h0);
        chk("rst_valid",  {31'h0, i_valid}, 32'h0);
        chk("rst_ireg",   {16'h0, i_reg}, 32'h0);
        chk("rst_ipc",    {16'h0, i_pc}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);

        // Back-to-back fetch, zero-latency memory
        do_reset(0, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("t1_first_req", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0000});
        chk("t1_valid_c1",  {31'h0, i_valid}, 32'h0);
        @(negedge clk);
        chk("t1_head_c2",   {15'h0, i_valid, i_pc}, {15'h0, 1'b1, 16'h0000});
        chk("t1_ireg_c2",   {16'h0, i_reg}, 32'h5A00);
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("t1_addr", acc_at(i), i);
        for (int i = 0; i < 3; i++) chk("t1_pop", pop_at(i), {16'(i), 16'(i) ^ 16'h5A00});

        // Backpressure: buffer fills after two words
        do_reset(1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("t2_nacc",   acc_q.size(), 2);
        chk("t2_addr0",  acc_at(0), 32'h0);
        chk("t2_addr1",  acc_at(1), 32'h1);
        chk("t2_idle",   {31'h0, mem_req}, 32'h0);
        chk("t2_head",   {15'h0, i_valid, i_reg}, {15'h0, 1'b1, 16'h5A00});
        i_ready = 1'b1;
        @(negedge clk);
        chk("t2_pop0_noreq", {15'h0, mem_req, i_pc}, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_pop0",  pop_at(0), 32'h0000_5A00);
        chk("t2_pop1",  pop_at(1), 32'h0001_5A01);
        chk("t2_resume", acc_at(2), 32'h2);

        // Redirect while address 5 is outstanding
        do_reset(0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h4) found = 1'b1;
        end
        chk("t3_reach4", {31'h0, found}, 32'h1);
        @(posedge clk); #1;
        chk("t3_addr5", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0005});
        ack_en = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        @(posedge clk); #1;
        redirect = 1'b0;
        acc_q.delete(); pop_q.delete();
        chk("t3_held",  {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0005});
        chk("t3_flush", {31'h0, i_valid}, 32'h0);
        @(posedge clk); #1;
        chk("t3_held2", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0005});
        ack_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t3_acc0", acc_at(0), 32'h0005);
        chk("t3_acc1", acc_at(1), 32'h0040);
        chk("t3_acc2", acc_at(2), 32'h0041);
        chk("t3_pop0", pop_at(0), 32'h0040_5A40);

        // Halt and redirect together with a request outstanding
        do_reset(0, 1'b1);
        repeat (3) @(posedge clk);
        #1 ack_en = 1'b0;
        @(posedge clk); #1;
        saved_addr = mem_addr;
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
        @(posedge clk); #1;
        halt = 1'b0; redirect = 1'b0;
        acc_q.delete(); pop_q.delete();
        chk("t4_held",   {14'h0, halted, mem_req, mem_addr}, {14'h0, 1'b0, 1'b1, saved_addr});
        chk("t4_flush",  {31'h0, i_valid}, 32'h0);
        ack_en = 1'b1;
        @(posedge clk); #1;
        chk("t4_halted", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            redirect = (i >= 5 && i < 8);
            @(negedge clk);
            chk("t4_hold", {29'h0, halted, mem_req, i_valid}, 32'h4);
        end
        redirect = 1'b0;
        chk("t4_nacc",  acc_q.size(), 1);
        chk("t4_acc0",  acc_at(0), {16'h0, saved_addr});
        chk("t4_npop",  pop_q.size(), 0);

        // PC wrap from 0xFFFF
        do_reset(0, 1'b1);
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(posedge clk); #1;
        redirect = 1'b0;
        acc_q.delete(); pop_q.delete();
        repeat (8) @(posedge clk);
        #1;
        chk("t5_acc0", acc_at(0), 32'hFFFF);
        chk("t5_acc1", acc_at(1), 32'h0000);
        chk("t5_acc2", acc_at(2), 32'h0001);
        chk("t5_pop0", pop_at(0), 32'hFFFF_A5FF);
        chk("t5_pop1", pop_at(1), 32'h0000_5A00);

        // Asynchronous reset in the middle of a request
        do_reset(3, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk("t6_pre", {30'h0, mem_req, i_valid}, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("t6_async", {14'h0, mem_req, i_valid, mem_addr}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; lat = 0;
        @(negedge clk); @(negedge clk);
        chk("t6_restart", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
